// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and ALU reference function for alu_op_sequencer
package alu_seq_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_LSL  = 4'd4,
    OP_LSR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EC   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } seq_state_e;

  // Expected ALU result plus which fields are meaningful for this op.
  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             carry;
    logic             chk_data;
    logic             chk_carry;
  } alu_exp_t;

  function automatic alu_exp_t alu_expect(input logic [ALU_W-1:0] a,
                                          input logic [ALU_W-1:0] b,
                                          input alu_op_e          op);
    logic [ALU_W:0]     sum;
    logic [2*ALU_W-1:0] prod;
    alu_exp_t           r;
    sum         = {1'b0, a} + {1'b0, b};
    prod        = {{ALU_W{1'b0}}, a} * {{ALU_W{1'b0}}, b};
    r.data      = '0;
    r.carry     = sum[ALU_W];
    r.chk_data  = 1'b1;
    // Carry out is only architecturally defined for the add.
    r.chk_carry = (op == OP_ADD);
    case (op)
      OP_ADD:  r.data = sum[ALU_W-1:0];
      OP_SUB:  r.data = a - b;
      OP_MUL:  r.data = prod[ALU_W-1:0];
      OP_DIV: begin
        // Divide by zero has no defined result, so it is never judged.
        if (b == '0) r.chk_data = 1'b0;
        else         r.data     = a / b;
      end
      OP_LSL:  r.data = {a[ALU_W-2:0], 1'b0};
      OP_LSR:  r.data = {1'b0, a[ALU_W-1:1]};
      OP_ROL:  r.data = {a[ALU_W-2:0], a[ALU_W-1]};
      OP_ROR:  r.data = {a[0], a[ALU_W-1:1]};
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_XOR:  r.data = a ^ b;
      OP_NOR:  r.data = ~(a | b);
      OP_NAND: r.data = ~(a & b);
      OP_XNOR: r.data = ~(a ^ b);
      OP_GT:   r.data = (a > b)  ? ALU_W'(1) : '0;
      OP_EC:   r.data = (a == b) ? ALU_W'(1) : '0;
      default: r.data = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational ALU reference, used when ALU_SEQ_SELF_CHECK_EN is defined
module alu_ref_model
  import alu_seq_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       op,
  output logic [ALU_W-1:0] exp_data,
  output logic             exp_carry,
  output logic             chk_data,
  output logic             chk_carry
);

  alu_exp_t r;

  // Evaluate the reference for the operands and opcode currently on the ALU.
  always_comb begin
    r         = alu_expect(a, b, alu_op_e'(op));
    exp_data  = r.data;
    exp_carry = r.carry;
    chk_data  = r.chk_data;
    chk_carry = r.chk_carry;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sweeps opcodes 0..15 over one operand pair; ALU_SEQ_SELF_CHECK_EN adds checking
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W         = 8,
  parameter int ALU_LAT   = 1,
  parameter int MUL_EXTRA = 1
`ifdef ALU_SEQ_SELF_CHECK_EN
  , parameter int CNT_W   = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_sel,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_op,
  output logic [W-1:0]     res_data,
  output logic             res_carry,
  output logic             busy,
  output logic             done
`ifdef ALU_SEQ_SELF_CHECK_EN
  , output logic           err_flag,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam int WAIT_W = 8;

  seq_state_e        state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [3:0]        sel_q, sel_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d, cnt_load;
  logic              res_valid_q, res_valid_d;
  logic [3:0]        res_op_q, res_op_d;
  logic [W-1:0]      res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              done_q, done_d;

  // The multiply takes longer inside the ALU, so it gets extra wait cycles.
  assign cnt_load = WAIT_W'(ALU_LAT - 1) + ((sel_q == 4'(OP_MUL)) ? WAIT_W'(MUL_EXTRA) : '0);

`ifdef ALU_SEQ_SELF_CHECK_EN
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [W-1:0]     exp_data;
  logic             exp_carry, chk_data, chk_carry, mismatch;

  alu_ref_model u_ref (
    .a         (a_q),
    .b         (b_q),
    .op        (sel_q),
    .exp_data  (exp_data),
    .exp_carry (exp_carry),
    .chk_data  (chk_data),
    .chk_carry (chk_carry)
  );

  assign mismatch = (chk_data && (alu_out != exp_data)) || (chk_carry && (alu_carry != exp_carry));
`endif

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> EMIT sweep.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_op_d    = res_op_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    done_d      = 1'b0;
`ifdef ALU_SEQ_SELF_CHECK_EN
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sel_d   = 4'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_load;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_data_d  = alu_out;
          res_carry_d = alu_carry;
          res_op_d    = sel_q;
          res_valid_d = 1'b1;
          state_d     = S_EMIT;
`ifdef ALU_SEQ_SELF_CHECK_EN
          err_flag_d  = mismatch;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
`ifdef ALU_SEQ_SELF_CHECK_EN
          err_flag_d  = 1'b0;
          if (err_flag_q && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
`endif
          if (sel_q == 4'd15) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sweep in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_op_q    <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_SEQ_SELF_CHECK_EN
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_op_q    <= res_op_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      done_q      <= done_d;
`ifdef ALU_SEQ_SELF_CHECK_EN
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign done      = done_q;
`ifdef ALU_SEQ_SELF_CHECK_EN
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer; ALU_SEQ_SELF_CHECK_EN adds error-port checks
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out = '0;
  logic       alu_carry = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_op;
  logic [7:0] res_data;
  logic       res_carry;
  logic       busy, done;
  logic       force_bad = 1'b0;
`ifdef ALU_SEQ_SELF_CHECK_EN
  logic       err_flag;
  logic [7:0] err_count;
  logic       got_e [16];
`endif

  int         errors = 0;
  int         checks = 0;
  int         lat    [16];
  logic [3:0] got_op [16];
  logic [7:0] got_d  [16];
  logic       got_c  [16];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_op    (res_op),
    .res_data  (res_data),
    .res_carry (res_carry),
    .busy      (busy),
`ifdef ALU_SEQ_SELF_CHECK_EN
    .done      (done),
    .err_flag  (err_flag),
    .err_count (err_count)
`else
    .done      (done)
`endif
  );

  // Stand-in for the 8-bit ALU: one registered cycle from operands/select to output.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s, input logic bad);
    logic [8:0]  sum;
    logic [15:0] prod;
    logic [7:0]  r;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {8'd0, a} * {8'd0, b};
    case (s)
      4'd0:  r = sum[7:0];
      4'd1:  r = a - b;
      4'd2:  r = prod[7:0];
      4'd3:  r = (b == 8'd0) ? 8'hFF : a / b;
      4'd4:  r = {a[6:0], 1'b0};
      4'd5:  r = {1'b0, a[7:1]};
      4'd6:  r = {a[6:0], a[7]};
      4'd7:  r = {a[0], a[7:1]};
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    if (bad && s == 4'd2) r = r ^ 8'h01;
    return {sum[8], r};
  endfunction

  always @(posedge clk) {alu_carry, alu_out} <= alu_fn(alu_a, alu_b, alu_sel, force_bad);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair; returns just after the accepting edge.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Consume a full sweep; optionally stall the beat of stall_op for stall_n cycles.
  task automatic collect(input int stall_op, input int stall_n, input logic [7:0] a_exp);
    int cyc;
    res_ready = (stall_op == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!res_valid && cyc < 50);
      chk("res_valid_seen", {15'd0, res_valid}, 16'd1);
      if (!res_valid) return;
      lat[i]    = cyc;
      got_op[i] = res_op;
      got_d[i]  = res_data;
      got_c[i]  = res_carry;
`ifdef ALU_SEQ_SELF_CHECK_EN
      got_e[i]  = err_flag;
`endif
      chk("res_op_order", {12'd0, res_op}, i[15:0]);
      if (i == stall_op) begin
        for (int k = 0; k < stall_n; k++) begin
          in_valid = 1'b1;
          in_a     = 8'h55;
          @(negedge clk);
          chk("stall_valid", {15'd0, res_valid}, 16'd1);
          chk("stall_data", {8'd0, res_data}, {8'd0, got_d[i]});
          chk("stall_sel", {12'd0, alu_sel}, i[15:0]);
          chk("busy_ignores_in_a", {8'd0, alu_a}, {8'd0, a_exp});
          chk("busy_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
      end
      @(posedge clk);
      #1 res_ready = (i + 1 == stall_op) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("idle_in_ready", {15'd0, in_ready}, 16'd1);
    chk("idle_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    chk("done_one_cycle", {15'd0, done}, 16'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
    chk("rst_alu_sel", {12'd0, alu_sel}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
`ifdef ALU_SEQ_SELF_CHECK_EN
    chk("rst_err_count", {8'd0, err_count}, 16'd0);
`endif
    rst = 1'b0;

    // 1: A=200, B=100 full sweep; op2 latency one cycle longer than op1
    send_pair(8'd200, 8'd100);
    collect(99, 0, 8'd200);
    chk("t1_op0_data", {8'd0, got_d[0]}, 16'd44);
    chk("t1_op0_carry", {15'd0, got_c[0]}, 16'd1);
    chk("t1_op1_data", {8'd0, got_d[1]}, 16'd100);
    chk("t1_op2_data", {8'd0, got_d[2]}, 16'd32);
    chk("t1_op3_data", {8'd0, got_d[3]}, 16'd2);
    chk("t1_op6_data", {8'd0, got_d[6]}, 16'h91);
    chk("t1_op11_data", {8'd0, got_d[11]}, 16'h13);
    chk("t1_op14_data", {8'd0, got_d[14]}, 16'd1);
    chk("t1_op15_data", {8'd0, got_d[15]}, 16'd0);
    chk("t5_op1_latency", lat[1][15:0], 16'd3);
    chk("t5_op2_latency", lat[2][15:0], 16'd4);
`ifdef ALU_SEQ_SELF_CHECK_EN
    chk("t1_err_count", {8'd0, err_count}, 16'd0);
`endif

    // 2: A=0, B=0; divide by zero must not be flagged
    send_pair(8'd0, 8'd0);
    collect(99, 0, 8'd0);
    chk("t2_op11_data", {8'd0, got_d[11]}, 16'hFF);
    chk("t2_op15_data", {8'd0, got_d[15]}, 16'd1);
    chk("t2_op0_carry", {15'd0, got_c[0]}, 16'd0);
`ifdef ALU_SEQ_SELF_CHECK_EN
    chk("t2_op3_err_flag", {15'd0, got_e[3]}, 16'd0);
    chk("t2_err_count", {8'd0, err_count}, 16'd0);
`endif

    // 3: A=0x81, stall the op6 beat 5 cycles while in_valid pokes a new pair
    send_pair(8'h81, 8'h02);
    collect(6, 5, 8'h81);
    chk("t3_op6_data", {8'd0, got_d[6]}, 16'h03);
    chk("t3_op7_data", {8'd0, got_d[7]}, 16'hC0);
    chk("t3_op5_data", {8'd0, got_d[5]}, 16'h40);

    // 4: reset during the op7 wait, then a fresh sweep starts at op 0
    send_pair(8'h12, 8'h34);
    res_ready = 1'b1;
    begin
      int cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (alu_sel != 4'd7 && cyc < 200);
    end
    chk("t4_reach_op7", {12'd0, alu_sel}, 16'd7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_rst_alu_sel", {12'd0, alu_sel}, 16'd0);
    chk("t4_rst_alu_a", {8'd0, alu_a}, 16'd0);
    chk("t4_rst_res_valid", {15'd0, res_valid}, 16'd0);
    chk("t4_rst_res_data", {8'd0, res_data}, 16'd0);
    chk("t4_rst_busy", {15'd0, busy}, 16'd0);
    chk("t4_rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    send_pair(8'h05, 8'h03);
    collect(99, 0, 8'h05);
    chk("t4_op0_data", {8'd0, got_d[0]}, 16'd8);
    chk("t4_op1_data", {8'd0, got_d[1]}, 16'd2);
    chk("t4_op2_data", {8'd0, got_d[2]}, 16'd15);

`ifdef ALU_SEQ_SELF_CHECK_EN
    // 6: ALU corrupts the multiply; A=16, B=16 expects 0x00
    force_bad = 1'b1;
    send_pair(8'd16, 8'd16);
    collect(99, 0, 8'd16);
    force_bad = 1'b0;
    chk("t6_op2_data", {8'd0, got_d[2]}, 16'd1);
    chk("t6_op2_err_flag", {15'd0, got_e[2]}, 16'd1);
    chk("t6_op1_err_flag", {15'd0, got_e[1]}, 16'd0);
    chk("t6_err_count", {8'd0, err_count}, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
